// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg -- shared types and constants for the FIR sequencing controller.
//
// Contents:
//   fir_state_t       : controller FSM state encoding (IDLE, MAC, DRAIN, DONE)
//   FIR_TAPS          : default number of filter taps (one MAC cycle per tap)
//   FIR_ADDR_W        : default tap address width, $clog2(FIR_TAPS)
//   FIR_DRAIN_CYCLES  : cycles spent flushing the product pipeline register
package fir_ctrl_pkg;

  localparam int FIR_TAPS         = 64;
  localparam int FIR_ADDR_W       = 6;
  localparam int FIR_DRAIN_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_state_t;

endpackage

// File: rtl/fir_controller_tap_counter.sv
// tap_counter -- tap index counter for the serial MAC sequence.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (count -> 0)
//   clear    in   synchronous clear to 0 (wins over enable)
//   enable   in   advance the count by one
//   count    out  current tap index, ADDR_W bits
//   terminal out  high while count == TAPS-1
module tap_counter #(
  parameter int TAPS   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/fir_controller.sv
// fir_controller -- sequencing controller for a serial multiply-accumulate FIR
// datapath. Accepts one sample per handshake, steps the datapath through all
// taps, waits one drain cycle for the product register, then pulses out_valid.
//
// Optional feature: define FIR_CTRL_DROP_DETECT_EN to build the sticky
// protocol-violation detector behind `dropped`; otherwise `dropped` is 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   source offers a sample on the datapath din
//   in_ready  out  controller can accept a sample (IDLE only)
//   shift     out  push din into the datapath input buffer
//   flush     out  clear datapath product and accumulator registers
//   address   out  tap index into input buffer and coefficient table
//   out_valid out  datapath dout holds the complete filter sum this cycle
//   busy      out  a computation is in progress
//   dropped   out  sticky protocol-violation flag
//   state     out  current FSM state, for observation
//
// Handshake: a sample transfers in exactly the cycles where in_valid and
// in_ready are both high; that cycle also asserts shift. The source must hold
// din and in_valid until then. There is no output backpressure: dout is only
// guaranteed during the single out_valid cycle.
module fir_controller
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS,
  parameter int ADDR_W = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift,
  output logic              flush,
  output logic [ADDR_W-1:0] address,
  output logic              out_valid,
  output logic              busy,
  output logic              dropped,
  output fir_state_t        state
);

  fir_state_t        cur_state;
  fir_state_t        nxt_state;
  logic [ADDR_W-1:0] count;
  logic              terminal;
  logic              cnt_clear;
  logic              cnt_enable;

  // Counter is held at 0 in IDLE and stops at TAPS-1, so it never wraps.
  assign cnt_clear  = (cur_state == IDLE);
  assign cnt_enable = (cur_state == MAC) && !terminal;

  tap_counter #(
    .TAPS   (TAPS),
    .ADDR_W (ADDR_W)
  ) u_tap_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .count    (count),
    .terminal (terminal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (in_valid) nxt_state = MAC;
      MAC:     if (terminal) nxt_state = DRAIN;
      DRAIN:   nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    in_ready  = 1'b0;
    flush     = 1'b0;
    address   = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (cur_state)
      IDLE: begin
        in_ready = 1'b1;
        flush    = 1'b1;
      end
      MAC: begin
        address = count;
        busy    = 1'b1;
      end
      // DRAIN keeps flush low so the last product lands in the accumulator.
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign shift = in_valid & in_ready;
  assign state = cur_state;

`ifdef FIR_CTRL_DROP_DETECT_EN
  // A rising in_valid while busy means the source started offering a new
  // sample that cannot be taken; flag it until reset.
  logic in_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_d <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      if (in_valid && !in_valid_d && busy) begin
        dropped <= 1'b1;
      end
    end
  end
`else
  assign dropped = 1'b0;
`endif

endmodule

// File: doc/fir_controller.md
# fir_controller

Sequencing controller for the 64-tap serial multiply-accumulate FIR datapath. It accepts one input sample per valid/ready handshake and drives the datapath's `shift`, `flush` and 6-bit coefficient/buffer `address` controls. It then reports the finished 38-bit result with a one-cycle `out_valid` pulse. It sits between the sample source and the datapath and owns all of the datapath's timing.

## Interface
Parameters:
- `TAPS`, 64: number of filter taps, one MAC per tap.
- `ADDR_W`, 6: address width, equal to $clog2(TAPS).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: the source offers a sample on the datapath `din`.
- `in_ready`, out, 1: the controller can accept a sample.
- `shift`, out, 1: push `din` into the datapath input buffer.
- `flush`, out, 1: clear the datapath product and accumulator registers.
- `address`, out, ADDR_W: tap index into the input buffer and coefficient table.
- `out_valid`, out, 1: the datapath `dout` holds the complete filter sum this cycle.
- `busy`, out, 1: a computation is in progress.
- `dropped`, out, 1: sticky protocol-violation flag (see Configuration).

## Operation
- Moore FSM. All outputs are decoded from the registered state and the tap counter. The exceptions are `shift`, which is `in_valid & in_ready`, and `dropped`, which is a register.
- The states are IDLE, MAC, DRAIN and DONE.
- **IDLE**
  - Outputs: `in_ready`=1, `flush`=1, `address`=0, `busy`=0.
  - On `in_valid`=1: `shift`=1 in the same cycle, the counter loads 0, and the next state is MAC.
- **MAC**
  - `address` = counter, which increments by 1 per cycle from 0 to TAPS-1.
  - Outputs: `flush`=0, `in_ready`=0, `busy`=1.
  - When counter = TAPS-1, the next state is DRAIN.
- **DRAIN**: exactly one cycle. `address`=0, `busy`=1. This cycle lets the last product, held in the product pipeline register, enter the accumulator.
- **DONE**: exactly one cycle. `out_valid`=1, `busy`=1, `flush`=0. The next state is IDLE.
- Counter behaviour: wrap-around never occurs. The counter does not advance outside MAC.
- `in_valid` outside IDLE is ignored, and no `shift` is issued. The source must hold the sample until it is accepted.
- No output backpressure. The downstream consumer must capture `dout` during the `out_valid` cycle, because the accumulator is corrupted on the following edge.

## Timing
- Reset values: state=IDLE, counter=0, `address`=0, `out_valid`=0, `shift`=0 (while `in_valid`=0), `flush`=1, `in_ready`=1, `busy`=0, `dropped`=0.
- Let the handshake cycle be C0, the cycle in which `in_valid & in_ready`=1.
- `address`=k in cycle C0+1+k, for k=0..63.
- DRAIN occurs in C0+65.
- `out_valid` occurs in C0+66, and `dout` equals Σ coeff[k]·x[k] in that cycle.
- The earliest next acceptance is C0+67. Throughput is therefore one sample per TAPS+3 cycles.
- Reset asserted mid-operation: the FSM returns to IDLE immediately (asynchronous). `out_valid` drops and `flush` rises in the same cycle. The partial sum is discarded, and the datapath buffer contents are retained.
- `in_valid` rising in the DONE cycle is not accepted until the next cycle (IDLE).

## Configuration
- Macro: `FIR_CTRL_DROP_DETECT_EN`.
- Defined:
  - `dropped` is set on any cycle where `in_valid`=1 and `in_ready`=0 while the previous cycle also had `in_valid`=1 and the data was presumably changed. The simplified rule is: set when `in_valid` rises (0 to 1) while `busy`=1.
  - Once set, `dropped` is cleared only by `rst`.
- Undefined: `dropped` is tied to 0 and no detection logic is generated.

## Structure
- Package `fir_ctrl_pkg`:
  - `fir_state_t` enum (IDLE, MAC, DRAIN, DONE).
  - Constants `FIR_TAPS`=64, `FIR_ADDR_W`=6, `FIR_DRAIN_CYCLES`=1.
- One sub-module, `tap_counter`: an ADDR_W-bit counter with synchronous clear, enable, and a terminal-count output at TAPS-1.

## Test plan
- Reset release with `in_valid`=0: `in_ready`=1, `flush`=1, `address`=0, `out_valid`=0 held for 10 cycles.
- Single sample offered at C0:
  - `shift` is high only in C0.
  - `address` steps 0..63 over C0+1..C0+64.
  - `out_valid` is high only in C0+66.
  - `in_ready` returns at C0+67.
- With the datapath, coeffs all 1, and 64 consecutive samples of 1: the 64th `out_valid` shows `dout`=64. With coeffs all 1 and a single sample of -3 after reset: `dout`=-3.
- `in_valid` held high continuously: exactly one `shift` every 67 cycles and no `shift` outside IDLE.
- `rst` pulsed at C0+30: the FSM is in IDLE the same cycle, `address`=0, no `out_valid`. A new sample is accepted on the first cycle after `rst` falls.
- With `FIR_CTRL_DROP_DETECT_EN`:
  - `in_valid` raised at C0+10 sets `dropped` at the next edge.
  - `dropped` stays 1 through the next sample.
  - `rst` clears it.
  - Without the macro, `dropped` stays 0.
